// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: detects alarm time match, rings for a bounded time, and handles snooze/dismiss.
module alarm_ring_ctrl #(
  parameter int RING_SECS   = 30,
  parameter int SNOOZE_SECS = 60,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       dicRun,
  input  logic       alarm_ena,
  input  logic [3:0] t_mt,
  input  logic [3:0] t_mo,
  input  logic [3:0] t_st,
  input  logic [3:0] t_so,
  input  logic [3:0] a_mt,
  input  logic [3:0] a_mo,
  input  logic [3:0] a_st,
  input  logic [3:0] a_so,
  input  logic       det_snooze,
  input  logic       det_dismiss,
  output logic       ring,
  output logic       buzz,
  output logic       snoozing,
  output logic [2:0] snz_cnt,
  output logic       ring_done
);
  localparam int RW = $clog2(RING_SECS + 1);
  localparam int SW = $clog2(SNOOZE_SECS + 1);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
  state_t        r_state, w_state;
  logic [RW-1:0] r_ring_cnt, w_ring_cnt;
  logic [SW-1:0] r_snz_tmr, w_snz_tmr;
  logic [2:0]    r_snz_cnt, w_snz_cnt;
  logic          r_blink, w_blink;
  logic          r_match, r_done, w_done;
  logic          w_match, w_hit, w_tick, w_quit;
  assign w_match = {t_mt, t_mo, t_st, t_so} == {a_mt, a_mo, a_st, a_so};
  assign w_hit   = alarm_ena & dicRun & w_match & ~r_match;
  assign w_tick  = tick_1hz & dicRun;
  assign w_quit  = ~alarm_ena | det_dismiss;
  always_comb begin
    w_state    = r_state;
    w_ring_cnt = r_ring_cnt;
    w_snz_tmr  = r_snz_tmr;
    w_snz_cnt  = r_snz_cnt;
    w_blink    = r_blink;
    unique case (r_state)
      IDLE: if (w_hit) begin
        w_state    = RING;
        w_ring_cnt = '0;
        w_snz_cnt  = '0;
        w_blink    = 1'b1;
      end
      RING: if (w_quit) w_state = IDLE;
      else if (det_snooze && r_snz_cnt < 3'(MAX_SNOOZE)) begin
        w_state   = SNOOZE;
        w_snz_cnt = r_snz_cnt + 3'd1;
        w_snz_tmr = '0;
      end else if (w_tick) begin
        w_blink    = ~r_blink;
        w_ring_cnt = r_ring_cnt + 1'b1;
        w_state    = (r_ring_cnt == RW'(RING_SECS - 1)) ? IDLE : RING;
      end
      SNOOZE: if (w_quit) w_state = IDLE;
      else if (w_tick) begin
        w_snz_tmr = r_snz_tmr + 1'b1;
        if (r_snz_tmr == SW'(SNOOZE_SECS - 1)) begin
          w_state    = RING;
          w_ring_cnt = '0;
          w_blink    = 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
    w_done = (r_state != IDLE) && (w_state == IDLE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ring_cnt <= '0;
      r_snz_tmr  <= '0;
      r_snz_cnt  <= '0;
      r_blink    <= 1'b0;
      r_match    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_ring_cnt <= w_ring_cnt;
      r_snz_tmr  <= w_snz_tmr;
      r_snz_cnt  <= w_snz_cnt;
      r_blink    <= w_blink;
      r_match    <= w_match;
      r_done     <= w_done;
    end
  end
  assign ring      = r_state == RING;
  assign buzz      = ring & r_blink;
  assign snoozing  = r_state == SNOOZE;
  assign snz_cnt   = r_snz_cnt;
  assign ring_done = r_done;
endmodule
